line_scan_sequencer: RTL and testbench

Upstream driver for the 3-to-8 line decoder. It scans the decoder's eight output lines in ascending order and presents Enable and the select bits {A,B,C} to the decoder input. Each line is held for a programmable dwell time, followed by a one-cycle blank with Enable low so that adjacent lines never overlap. A per-line mask selects which lines take part in the scan. The scan runs once or repeats continuously, and can be aborted at any point.

---
 rtl/line_scan_pkg.sv | 13 +
 rtl/next_line_finder.sv | 28 ++
 rtl/line_scan_sequencer.sv | 144 ++++++++++++++
 tb/tb_line_scan_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/line_scan_pkg.sv
// rtl/line_scan_pkg.sv - shared types and constants for the line scan sequencer
package line_scan_pkg;

   localparam int SEL_W     = 3;
   localparam int NUM_LINES = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      BLANK = 2'd2
   } state_t;

endpackage

// File: rtl/next_line_finder.sv
// rtl/next_line_finder.sv - finds the lowest set mask bit and the next set bit above cur
module next_line_finder
   import line_scan_pkg::*;
(
   input  logic [NUM_LINES-1:0] mask,
   input  logic [SEL_W-1:0]     cur,
   output logic [SEL_W-1:0]     next_idx,
   output logic                 has_next,
   output logic [SEL_W-1:0]     first_idx
);

   // Scan downwards so the last hit wins, leaving the lowest qualifying index.
   always_comb begin
      first_idx = '0;
      next_idx  = cur;
      has_next  = 1'b0;
      for (int i = NUM_LINES - 1; i >= 0; i--) begin
         if (mask[i]) begin
            first_idx = SEL_W'(i);
         end
         if (mask[i] && (i > int'(cur))) begin
            has_next = 1'b1;
            next_idx = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/line_scan_sequencer.sv
// rtl/line_scan_sequencer.sv - scans enabled 3-to-8 decoder lines with dwell and blanking
module line_scan_sequencer
   import line_scan_pkg::*;
#(
   parameter int DWELL_W   = 8,
   parameter int NUM_LINES = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 continuous,
   input  logic [DWELL_W-1:0]   dwell,
   input  logic [NUM_LINES-1:0] line_mask,
   output logic                 Enable,
   output logic                 A,
   output logic                 B,
   output logic                 C,
   output logic                 busy,
   output logic                 done
);

   state_t                 state, state_n;
   logic                   enable_r, enable_n;
   logic [SEL_W-1:0]       sel_r, sel_n;
   logic                   busy_r, busy_n;
   logic                   done_r, done_n;
   logic [DWELL_W-1:0]     cnt, cnt_n;
   logic [DWELL_W-1:0]     dwell_l, dwell_n;
   logic [NUM_LINES-1:0]   mask_l, mask_n;
   logic                   cont_l, cont_n;

   logic [NUM_LINES-1:0]   find_mask;
   logic [SEL_W-1:0]       next_idx;
   logic                   has_next;
   logic [SEL_W-1:0]       first_idx;

   // In IDLE the finder looks at the live mask to pick the first line; afterwards the latched one.
   assign find_mask = (state == IDLE) ? line_mask : mask_l;

   next_line_finder u_finder (
      .mask      (find_mask),
      .cur       (sel_r),
      .next_idx  (next_idx),
      .has_next  (has_next),
      .first_idx (first_idx)
   );

   // Next-state and registered-output values; outputs are flops, so they lead the state by nothing.
   always_comb begin
      state_n  = state;
      enable_n = 1'b0;
      sel_n    = sel_r;
      busy_n   = busy_r;
      done_n   = 1'b0;
      cnt_n    = cnt;
      dwell_n  = dwell_l;
      mask_n   = mask_l;
      cont_n   = cont_l;
      case (state)
         IDLE: begin
            busy_n = 1'b0;
            if (start && !stop && (line_mask != '0)) begin
               state_n  = DRIVE;
               enable_n = 1'b1;
               sel_n    = first_idx;
               busy_n   = 1'b1;
               dwell_n  = (dwell == '0) ? DWELL_W'(1) : dwell;
               cnt_n    = (dwell == '0) ? DWELL_W'(1) : dwell;
               mask_n   = line_mask;
               cont_n   = continuous;
            end
         end
         DRIVE: begin
            if (stop) begin
               state_n = IDLE;
               busy_n  = 1'b0;
            end else if (cnt <= DWELL_W'(1)) begin
               state_n = BLANK;
               done_n  = !has_next && !cont_l;
            end else begin
               enable_n = 1'b1;
               cnt_n    = cnt - DWELL_W'(1);
            end
         end
         BLANK: begin
            if (stop) begin
               state_n = IDLE;
               busy_n  = 1'b0;
            end else if (has_next) begin
               state_n  = DRIVE;
               enable_n = 1'b1;
               sel_n    = next_idx;
               cnt_n    = dwell_l;
            end else if (cont_l) begin
               state_n  = DRIVE;
               enable_n = 1'b1;
               sel_n    = first_idx;
               cnt_n    = dwell_l;
            end else begin
               state_n = IDLE;
               busy_n  = 1'b0;
            end
         end
         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset clears the decoder drive immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         enable_r <= 1'b0;
         sel_r    <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         cnt      <= '0;
         dwell_l  <= '0;
         mask_l   <= '0;
         cont_l   <= 1'b0;
      end else begin
         state    <= state_n;
         enable_r <= enable_n;
         sel_r    <= sel_n;
         busy_r   <= busy_n;
         done_r   <= done_n;
         cnt      <= cnt_n;
         dwell_l  <= dwell_n;
         mask_l   <= mask_n;
         cont_l   <= cont_n;
      end
   end

   assign Enable = enable_r;
   assign A      = sel_r[2];
   assign B      = sel_r[1];
   assign C      = sel_r[0];
   assign busy   = busy_r;
   assign done   = done_r;

endmodule

// File: tb/tb_line_scan_sequencer.sv
// tb/tb_line_scan_sequencer.sv - directed self-checking bench for line_scan_sequencer
module tb_line_scan_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic       continuous;
   logic [7:0] dwell;
   logic [7:0] line_mask;
   logic       Enable, A, B, C, busy, done;

   int checks;
   int errors;

   line_scan_sequencer #(.DWELL_W(8), .NUM_LINES(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .continuous (continuous),
      .dwell      (dwell),
      .line_mask  (line_mask),
      .Enable     (Enable),
      .A          (A),
      .B          (B),
      .C          (C),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag, input logic en, input logic [2:0] sel,
                                input logic bsy, input logic dn);
      check({tag, " en"},   32'(Enable),    32'(en));
      check({tag, " sel"},  32'({A, B, C}), 32'(sel));
      check({tag, " busy"}, 32'(busy),      32'(bsy));
      check({tag, " done"}, 32'(done),      32'(dn));
   endtask

   // Raise start during one cycle; it is sampled on the following rising edge.
   task automatic pulse_start(input logic [7:0] m, input logic [7:0] d, input logic cont, input logic stp);
      @(negedge clk);
      line_mask  = m;
      dwell      = d;
      continuous = cont;
      start      = 1'b1;
      stop       = stp;
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
   endtask

   initial begin
      logic [2:0] exp_sel;
      logic       exp_en;
      logic [4:0] sp_en, sp_done, sp_busy;
      logic [2:0] sp_sel [5];

      checks     = 0;
      errors     = 0;
      rst_n      = 1'b0;
      start      = 1'b0;
      stop       = 1'b0;
      continuous = 1'b0;
      dwell      = 8'd0;
      line_mask  = 8'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset state after idling
      repeat (5) @(negedge clk);
      check_outputs("reset", 1'b0, 3'd0, 1'b0, 1'b0);

      // Full single pass, mask 0xFF, dwell 2: line i on at 1+3i and 2+3i, blank at 3+3i
      pulse_start(8'hFF, 8'd2, 1'b0, 1'b0);
      for (int cyc = 1; cyc <= 25; cyc++) begin
         @(negedge clk);
         exp_en  = (cyc <= 24) && (((cyc - 1) % 3) != 2);
         exp_sel = (cyc <= 24) ? 3'((cyc - 1) / 3) : 3'd7;
         check_outputs($sformatf("pass c%0d", cyc), exp_en, exp_sel, cyc <= 24, cyc == 24);
      end

      // Sparse mask 0x81, dwell 0 behaves as 1
      sp_en   = 5'b00101;
      sp_busy = 5'b01111;
      sp_done = 5'b01000;
      sp_sel[0] = 3'd0; sp_sel[1] = 3'd0; sp_sel[2] = 3'd7; sp_sel[3] = 3'd7; sp_sel[4] = 3'd7;
      pulse_start(8'h81, 8'd0, 1'b0, 1'b0);
      for (int cyc = 1; cyc <= 5; cyc++) begin
         @(negedge clk);
         check_outputs($sformatf("sparse c%0d", cyc), sp_en[cyc-1], sp_sel[cyc-1],
                       sp_busy[cyc-1], sp_done[cyc-1]);
      end

      // Continuous wrap over lines 1 and 2, dwell 1
      pulse_start(8'h06, 8'd1, 1'b1, 1'b0);
      line_mask = 8'hFF;
      dwell     = 8'd9;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk);
         exp_en  = (cyc % 2) == 1;
         exp_sel = ((((cyc - 1) / 2) % 2) == 0) ? 3'd1 : 3'd2;
         check_outputs($sformatf("cont c%0d", cyc), exp_en, exp_sel, 1'b1, 1'b0);
      end
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      @(negedge clk);
      check_outputs("cont stop", 1'b0, 3'd2, 1'b0, 1'b0);
      @(negedge clk);
      check_outputs("cont stop+1", 1'b0, 3'd2, 1'b0, 1'b0);

      // Empty mask: no scan, no done
      pulse_start(8'h00, 8'd3, 1'b0, 1'b0);
      for (int cyc = 1; cyc <= 3; cyc++) begin
         @(negedge clk);
         check_outputs($sformatf("nomask c%0d", cyc), 1'b0, 3'd2, 1'b0, 1'b0);
      end

      // Start and stop together: stop wins
      pulse_start(8'hFF, 8'd3, 1'b0, 1'b1);
      for (int cyc = 1; cyc <= 3; cyc++) begin
         @(negedge clk);
         check_outputs($sformatf("startstop c%0d", cyc), 1'b0, 3'd2, 1'b0, 1'b0);
      end

      // Asynchronous reset while line 3 is driven (dwell 5: line 3 on at cycles 19..23)
      pulse_start(8'hFF, 8'd5, 1'b0, 1'b0);
      for (int cyc = 1; cyc <= 20; cyc++) @(negedge clk);
      check_outputs("pre-reset", 1'b1, 3'd3, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs("async reset", 1'b0, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_outputs("post reset", 1'b0, 3'd0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
